// File: rtl/sysid_chk_pkg.sv
// Shared types for the system ID checker: FSM state encoding and sysid slave word addresses.
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    DONE
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/system_0_sysid_checker.sv
// Reads system ID (word 0) and build timestamp (word 1) from the sysid slave and flags match/mismatch/timeout.
// Zero-wait slave: start to done in 3 cycles; each request holds read/address until waitrequest drops.
module system_0_sysid_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'h0000_0000,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'h67BE_1924,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             auto_pend;
  logic [CNT_W-1:0] tmo_cnt;
  logic             expired;
  logic             capture;
  logic             to_hit;
  logic             word_ts;
  logic             req_entry;
  logic             restart;

  assign expired   = (tmo_cnt == CNT_LAST);
  assign word_ts   = (state == TS_REQ) || (state == TS_WAIT);
  assign req_entry = (state_nxt != state) && ((state_nxt == ID_REQ) || (state_nxt == TS_REQ));
  assign restart   = req_entry && (state_nxt == ID_REQ);

  always_comb begin
    state_nxt   = state;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    busy        = 1'b0;
    done        = 1'b0;
    capture     = 1'b0;
    to_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (start || auto_pend) state_nxt = ID_REQ;
      end
      ID_REQ, TS_REQ: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = (state == TS_REQ) ? ADDR_TS : ADDR_ID;
        // Data returned in the accept cycle is taken here and the WAIT state is skipped.
        capture     = !avm_waitrequest && avm_readdatavalid;
        if (capture) begin
          state_nxt = (state == ID_REQ) ? TS_REQ : DONE;
        end else if (expired) begin
          state_nxt = DONE;
          to_hit    = 1'b1;
        end else if (!avm_waitrequest) begin
          state_nxt = (state == ID_REQ) ? ID_WAIT : TS_WAIT;
        end
      end
      ID_WAIT, TS_WAIT: begin
        busy        = 1'b1;
        avm_address = (state == TS_WAIT) ? ADDR_TS : ADDR_ID;
        capture     = avm_readdatavalid;
        if (capture) begin
          state_nxt = (state == ID_WAIT) ? TS_REQ : DONE;
        end else if (expired) begin
          state_nxt = DONE;
          to_hit    = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = ID_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      auto_pend <= AUTO_START;
      tmo_cnt   <= '0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      auto_pend <= 1'b0;
      if (req_entry)  tmo_cnt <= '0;
      else if (busy)  tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (restart) begin
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end
      // Flags are compared against the bus word directly so they land together with done.
      if (capture && !word_ts) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXP_ID);
      end
      if (capture && word_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXP_TIMESTAMP);
      end
      if (to_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Randomized bench for the sysid checker: an Avalon slave model with per-word stall/latency and a result model.
module tb_system_0_sysid_checker;

  localparam logic [31:0] EXP_ID_V = 32'h0000_0000;
  localparam logic [31:0] EXP_TS_V = 32'h67BE_1924;
  localparam int          T        = 16;
  localparam int          NEVER    = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest   = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata      = 32'h0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  always #5 clock = ~clock;

  system_0_sysid_checker #(
    .EXP_ID(EXP_ID_V), .EXP_TIMESTAMP(EXP_TS_V), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Slave configuration per word: stall cycles, accept-to-data latency, returned data.
  int          w_cfg [2];
  int          l_cfg [2];
  logic [31:0] d_cfg [2];

  int          age     = 0;
  bit          pend    = 1'b0;
  int          pend_cd = 0;
  logic [31:0] pend_dat;
  int          reads   = 0;
  bit          prev_stall = 1'b0;
  logic        prev_addr  = 1'b0;
  int          sa;

  always @(negedge clock) begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    if (reset) begin
      pend       = 1'b0;
      age        = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !done) begin
        chk("stall_read_held", avm_read, 1'b1);
        chk("stall_addr_held", avm_address, prev_addr);
      end
      prev_stall = 1'b0;
      if (pend) begin
        pend_cd--;
        if (pend_cd == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_dat;
          pend              = 1'b0;
        end
      end
      if (avm_read) begin
        sa = int'(avm_address);
        if (age < w_cfg[sa]) begin
          avm_waitrequest = 1'b1;
          age++;
          prev_stall = 1'b1;
          prev_addr  = avm_address;
        end else begin
          reads++;
          age = 0;
          if (l_cfg[sa] == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = d_cfg[sa];
          end else if (l_cfg[sa] != NEVER) begin
            pend     = 1'b1;
            pend_cd  = l_cfg[sa];
            pend_dat = d_cfg[sa];
          end
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic set_cfg(input int w0, input int l0, input logic [31:0] d0,
                         input int w1, input int l1, input logic [31:0] d1);
    w_cfg[0] = w0; l_cfg[0] = l0; d_cfg[0] = d0;
    w_cfg[1] = w1; l_cfg[1] = l1; d_cfg[1] = d1;
  endtask

  task automatic chk_reset(input string tag);
    chk($sformatf("%s.ctl", tag), {busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}, 7'b0);
    chk($sformatf("%s.id_value", tag), id_value, 32'h0);
    chk($sformatf("%s.ts_value", tag), ts_value, 32'h0);
  endtask

  // Launches one check (start pulse or reset release) and compares the outcome against the model.
  task automatic run_check(input string name, input bit via_reset, input int mid_seed);
    bit id_to, ts_to, e_id_ok, e_ts_ok;
    int n0, n1, exp_reads, c0, dcyc, mid;
    id_to     = (l_cfg[0] == NEVER) || (w_cfg[0] + l_cfg[0] >= T);
    n0        = id_to ? T : w_cfg[0] + l_cfg[0] + 1;
    ts_to     = !id_to && ((l_cfg[1] == NEVER) || (w_cfg[1] + l_cfg[1] >= T));
    n1        = id_to ? 0 : (ts_to ? T : w_cfg[1] + l_cfg[1] + 1);
    exp_reads = ((w_cfg[0] < T) ? 1 : 0) + ((!id_to && w_cfg[1] < T) ? 1 : 0);
    e_id_ok   = !id_to && (d_cfg[0] == EXP_ID_V);
    e_ts_ok   = !id_to && !ts_to && (d_cfg[1] == EXP_TS_V);
    mid       = (mid_seed >= 0) ? (mid_seed % (n0 + n1)) : -1;
    reads     = 0;
    if (via_reset) reset = 1'b0;
    else           start = 1'b1;
    c0   = cyc;
    dcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      start = (mid >= 0) && (cyc == c0 + 1 + mid);
      if (cyc == c0 + 1)
        chk($sformatf("%s.entry_flags", name), {busy, done, id_ok, ts_ok, timeout}, 5'b10000);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    start = 1'b0;
    chk($sformatf("%s.latency", name), dcyc - c0, 1 + n0 + n1);
    chk($sformatf("%s.id_ok", name), id_ok, e_id_ok);
    chk($sformatf("%s.ts_ok", name), ts_ok, e_ts_ok);
    chk($sformatf("%s.timeout", name), timeout, id_to || ts_to);
    chk($sformatf("%s.busy", name), busy, 1'b0);
    chk($sformatf("%s.reads", name), reads, exp_reads);
    if (!id_to) chk($sformatf("%s.id_value", name), id_value, d_cfg[0]);
    if (!id_to && !ts_to) chk($sformatf("%s.ts_value", name), ts_value, d_cfg[1]);
    for (int i = 0; i < 40 && pend; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    chk($sformatf("%s.sticky", name), {done, id_ok, ts_ok, timeout},
        {1'b1, e_id_ok, e_ts_ok, id_to || ts_to});
  endtask

  initial begin
    int c0;
    set_cfg(0, 0, EXP_ID_V, 0, 0, EXP_TS_V);
    repeat (3) @(negedge clock);
    chk_reset("reset");
    run_check("auto_start", 1'b1, -1);

    set_cfg(0, 0, EXP_ID_V, 0, 0, 32'h67BE_1925);
    run_check("bad_ts", 1'b0, -1);

    set_cfg(5, 2, EXP_ID_V, 5, 2, EXP_TS_V);
    run_check("stalled", 1'b0, -1);

    set_cfg(0, 0, EXP_ID_V, 0, NEVER, EXP_TS_V);
    run_check("ts_timeout", 1'b0, -1);

    set_cfg(2, 2, EXP_ID_V, 2, 2, EXP_TS_V);
    run_check("mid_start", 1'b0, 3);

    // Reset while waiting for the ID word, then rerun from reset release.
    set_cfg(0, 5, EXP_ID_V, 0, 0, EXP_TS_V);
    reads = 0;
    start = 1'b1;
    c0    = cyc;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("rst_wait.state", {busy, avm_read, cyc - c0 == 2}, 3'b101);
    reset = 1'b1;
    @(negedge clock);
    chk_reset("rst_wait");
    l_cfg[0] = 0;
    run_check("rst_rerun", 1'b1, -1);

    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < 2; w++) begin
        w_cfg[w] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 18)) : int'($urandom_range(0, 4));
        l_cfg[w] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
        d_cfg[w] = ($urandom_range(0, 3) == 0) ? $urandom : ((w == 0) ? EXP_ID_V : EXP_TS_V);
      end
      run_check($sformatf("rnd%0d", it), 1'b0,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
